// File: rtl/opicorv32_pkg.sv
// Shared types and constants for the opicorv32 memory interface.
package opicorv32_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NSTRB = XLEN / 8;

    // mem_wordsize encodings
    localparam logic [1:0] MEM_WORD = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_BYTE = 2'd2;
    localparam logic [1:0] MEM_RSVD = 2'd3;

    typedef enum logic [1:0] {
        MEMIF_IDLE       = 2'd0,
        MEMIF_READ       = 2'd1,
        MEMIF_WRITE      = 2'd2,
        MEMIF_PREFETCHED = 2'd3
    } memif_state_e;

    // Registered bus request payload, held stable until the handshake completes.
    typedef struct packed {
        logic              instr;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [NSTRB-1:0]  wstrb;
    } memif_req_t;

    // True when a data access cannot be issued for this size/byte-offset pair.
    function automatic logic size_offset_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            MEM_WORD: bad = (off != 2'b00);
            MEM_HALF: bad = off[0];
            MEM_BYTE: bad = 1'b0;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/opicorv32_memif_lanes.sv
// Byte-lane formatting: store data/strobe replication and load lane extraction.
module opicorv32_memif_lanes
    import opicorv32_pkg::*;
(
    input  logic [1:0]       i_st_size,
    input  logic [1:0]       i_st_off,
    input  logic [XLEN-1:0]  i_st_data,
    output logic [XLEN-1:0]  o_st_wdata,
    output logic [NSTRB-1:0] o_st_wstrb,
    input  logic [1:0]       i_ld_size,
    input  logic [1:0]       i_ld_off,
    input  logic [XLEN-1:0]  i_ld_data,
    output logic [XLEN-1:0]  o_ld_word
);

    // Store side: replicate the operand across lanes and pick the strobes.
    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = '0;
        case (i_st_size)
            MEM_WORD: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
            MEM_HALF: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = i_st_off[1] ? 4'b1100 : 4'b0011;
            end
            MEM_BYTE: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'(4'b0001 << i_st_off);
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = '0;
            end
        endcase
    end

    // Load side: select the addressed lane and zero-extend it.
    always_comb begin
        o_ld_word = i_ld_data;
        case (i_ld_size)
            MEM_HALF: begin
                o_ld_word = i_ld_off[1] ? {16'h0000, i_ld_data[31:16]}
                                        : {16'h0000, i_ld_data[15:0]};
            end
            MEM_BYTE: begin
                case (i_ld_off)
                    2'd0:    o_ld_word = {24'h000000, i_ld_data[7:0]};
                    2'd1:    o_ld_word = {24'h000000, i_ld_data[15:8]};
                    2'd2:    o_ld_word = {24'h000000, i_ld_data[23:16]};
                    default: o_ld_word = {24'h000000, i_ld_data[31:24]};
                endcase
            end
            default: o_ld_word = i_ld_data;
        endcase
    end

endmodule

// File: rtl/opicorv32_memif.sv
// Memory interface FSM: turns fetch/load/store requests into a valid/ready bus transfer.
module opicorv32_memif
    import opicorv32_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_do_rinst,
    input  logic             mem_do_prefetch,
    input  logic             mem_do_rdata,
    input  logic             mem_do_wdata,
    input  logic [1:0]       mem_wordsize,
    input  logic [XLEN-1:0]  next_pc,
    input  logic [XLEN-1:0]  reg_op1,
    input  logic [XLEN-1:0]  reg_op2,
    input  logic             mem_ready,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             mem_valid,
    output logic             mem_instr,
    output logic [XLEN-1:0]  mem_addr,
    output logic [XLEN-1:0]  mem_wdata,
    output logic [NSTRB-1:0] mem_wstrb,
    output logic             mem_done,
    output logic [XLEN-1:0]  mem_rdata_word,
    output logic             mem_error
);

    memif_state_e     r_state, w_state_nxt;
    memif_req_t       r_req, w_req_nxt;
    logic             r_valid, w_valid_nxt;
    logic [1:0]       r_off, w_off_nxt;
    logic [1:0]       r_size, w_size_nxt;
    logic             r_error, w_error_nxt;

    logic             w_xfer;
    logic             w_fetch_req;
    logic             w_data_bad;
    logic [XLEN-1:0]  w_st_wdata;
    logic [NSTRB-1:0] w_st_wstrb;
    logic [1:0]       w_unused_pc;

    // Fetches are always word aligned, so the low PC bits carry no information.
    assign w_unused_pc = next_pc[1:0];

    assign w_xfer      = r_valid & mem_ready;
    assign w_fetch_req = mem_do_rinst | mem_do_prefetch;
    assign w_data_bad  = size_offset_bad(mem_wordsize, reg_op1[1:0]);

    // Store formatting uses the live operands; load extraction uses the issue-time offset/size.
    opicorv32_memif_lanes u_lanes (
        .i_st_size  (mem_wordsize),
        .i_st_off   (reg_op1[1:0]),
        .i_st_data  (reg_op2),
        .o_st_wdata (w_st_wdata),
        .o_st_wstrb (w_st_wstrb),
        .i_ld_size  (r_size),
        .i_ld_off   (r_off),
        .i_ld_data  (mem_rdata),
        .o_ld_word  (mem_rdata_word)
    );

    // Next-state and next-request logic; fetch beats data load beats store.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_valid_nxt = r_valid;
        w_off_nxt   = r_off;
        w_size_nxt  = r_size;
        w_error_nxt = 1'b0;
        case (r_state)
            MEMIF_IDLE: begin
                if (w_fetch_req) begin
                    w_valid_nxt     = 1'b1;
                    w_req_nxt.instr = 1'b1;
                    w_req_nxt.addr  = {next_pc[XLEN-1:2], 2'b00};
                    w_req_nxt.wstrb = '0;
                    w_off_nxt       = 2'b00;
                    w_size_nxt      = MEM_WORD;
                    w_state_nxt     = MEMIF_READ;
                end else if (mem_do_rdata) begin
                    if (w_data_bad) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_valid_nxt     = 1'b1;
                        w_req_nxt.instr = 1'b0;
                        w_req_nxt.addr  = {reg_op1[XLEN-1:2], 2'b00};
                        w_req_nxt.wstrb = '0;
                        w_off_nxt       = reg_op1[1:0];
                        w_size_nxt      = mem_wordsize;
                        w_state_nxt     = MEMIF_READ;
                    end
                end else if (mem_do_wdata) begin
                    if (w_data_bad) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_valid_nxt     = 1'b1;
                        w_req_nxt.instr = 1'b0;
                        w_req_nxt.addr  = {reg_op1[XLEN-1:2], 2'b00};
                        w_req_nxt.wdata = w_st_wdata;
                        w_req_nxt.wstrb = w_st_wstrb;
                        w_off_nxt       = reg_op1[1:0];
                        w_size_nxt      = mem_wordsize;
                        w_state_nxt     = MEMIF_WRITE;
                    end
                end
            end
            MEMIF_READ: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = (mem_do_rinst | mem_do_rdata) ? MEMIF_IDLE : MEMIF_PREFETCHED;
                end
            end
            MEMIF_WRITE: begin
                if (w_xfer) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = MEMIF_IDLE;
                end
            end
            MEMIF_PREFETCHED: begin
                if (mem_do_rinst) begin
                    w_state_nxt = MEMIF_IDLE;
                end
            end
            default: w_state_nxt = MEMIF_IDLE;
        endcase
    end

    // State and request registers; reset clears everything, even mid-transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= MEMIF_IDLE;
            r_req   <= '0;
            r_valid <= 1'b0;
            r_off   <= 2'b00;
            r_size  <= MEM_WORD;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_valid <= w_valid_nxt;
            r_off   <= w_off_nxt;
            r_size  <= w_size_nxt;
            r_error <= w_error_nxt;
        end
    end

    assign mem_valid = r_valid;
    assign mem_instr = r_req.instr;
    assign mem_addr  = r_req.addr;
    assign mem_wdata = r_req.wdata;
    assign mem_wstrb = r_req.wstrb;
    assign mem_error = r_error;

    // Completion pulse: handshake of a still-requested transfer, or a fetch claiming a prefetch.
    assign mem_done = resetn &
                      ((w_xfer & (r_state != MEMIF_IDLE) & (mem_do_rinst | mem_do_rdata | mem_do_wdata)) |
                       ((r_state == MEMIF_PREFETCHED) & mem_do_rinst));

endmodule

// File: tb/tb_opicorv32_memif.sv
// Randomized transaction bench for opicorv32_memif with a transaction-level expectation model.
module tb_opicorv32_memif;

    logic        clk;
    logic        resetn;
    logic        mem_do_rinst, mem_do_prefetch, mem_do_rdata, mem_do_wdata;
    logic [1:0]  mem_wordsize;
    logic [31:0] next_pc, reg_op1, reg_op2;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_valid, mem_instr, mem_done, mem_error;
    logic [31:0] mem_addr, mem_wdata, mem_rdata_word;
    logic [3:0]  mem_wstrb;

    opicorv32_memif dut (
        .clk            (clk),
        .resetn         (resetn),
        .mem_do_rinst   (mem_do_rinst),
        .mem_do_prefetch(mem_do_prefetch),
        .mem_do_rdata   (mem_do_rdata),
        .mem_do_wdata   (mem_do_wdata),
        .mem_wordsize   (mem_wordsize),
        .next_pc        (next_pc),
        .reg_op1        (reg_op1),
        .reg_op2        (reg_op2),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .mem_valid      (mem_valid),
        .mem_instr      (mem_instr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .mem_done       (mem_done),
        .mem_rdata_word (mem_rdata_word),
        .mem_error      (mem_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs for the current cycle, written by the stimulus process.
    bit          model_en   = 1'b1;
    bit          m_valid    = 1'b0;
    bit          m_done     = 1'b0;
    bit          m_err      = 1'b0;
    bit          m_chk_rw   = 1'b0;
    bit          m_chk_all  = 1'b1;
    bit          m_is_read  = 1'b1;
    bit          m_instr    = 1'b0;
    logic [31:0] m_addr     = '0;
    logic [31:0] m_wdata    = '0;
    logic [3:0]  m_wstrb    = '0;
    logic [31:0] m_rw       = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Single compare process, sampling on the falling edge.
    always @(negedge clk) begin
        if (model_en) begin
            chk("mem_valid", 32'(mem_valid), 32'(m_valid));
            chk("mem_done",  32'(mem_done),  32'(m_done));
            chk("mem_error", 32'(mem_error), 32'(m_err));
            if (m_valid || m_chk_all) begin
                chk("mem_addr",  mem_addr,          m_addr);
                chk("mem_instr", 32'(mem_instr),    32'(m_instr));
                chk("mem_wstrb", 32'(mem_wstrb),    32'(m_wstrb));
                if (!m_is_read || m_chk_all)
                    chk("mem_wdata", mem_wdata, m_wdata);
            end
            if (m_chk_rw)
                chk("mem_rdata_word", mem_rdata_word, m_rw);
        end
    end

    // ---- reference rules ----
    function automatic bit bad_of(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'd3) || (size == 2'd0 && off != 2'd0) || (size == 2'd1 && off[0]);
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] v);
        case (size)
            2'd1:    return (v & 32'h0000_FFFF) * 32'h0001_0001;
            2'd2:    return (v & 32'h0000_00FF) * 32'h0101_0101;
            default: return v;
        endcase
    endfunction

    function automatic logic [3:0] strb_of(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'hF;
            2'd1:    return 4'(4'h3 << off);
            2'd2:    return 4'(4'h1 << off);
            default: return 4'h0;
        endcase
    endfunction

    function automatic logic [31:0] rw_of(input logic [1:0] size, input logic [1:0] off, input logic [31:0] rd);
        case (size)
            2'd1:    return (rd >> (8 * off)) & 32'h0000_FFFF;
            2'd2:    return (rd >> (8 * off)) & 32'h0000_00FF;
            default: return rd;
        endcase
    endfunction

    task automatic all_low();
        mem_do_rinst = 0; mem_do_prefetch = 0; mem_do_rdata = 0; mem_do_wdata = 0;
    endtask

    task automatic idle_model();
        m_valid = 0; m_done = 0; m_err = 0; m_chk_rw = 0;
    endtask

    // Bus handshake phase; entered just after the edge that issued the request.
    task automatic bus_phase(input bit is_read, input bit instr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wstrb,
                             input logic [31:0] rd, input logic [31:0] rw,
                             input int delay, input bit drop, output bit pf);
        bit hi;
        pf = 0;
        m_valid = 1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb;
        m_instr = instr; m_is_read = is_read; m_rw = rw;
        for (int d = 0; d <= delay; d++) begin
            if (drop && d == 0) all_low();
            mem_ready = (d == delay);
            mem_rdata = (d == delay) ? rd : $urandom;
            hi = mem_do_rinst | mem_do_rdata | mem_do_wdata;
            m_done   = (d == delay) && hi;
            m_chk_rw = m_done && is_read;
            if (d == delay) pf = is_read && !(mem_do_rinst | mem_do_rdata);
            @(posedge clk); #1;
        end
        mem_ready = 0;
        idle_model();
    endtask

    // kind: 0 fetch, 1 prefetch, 2 load, 3 store. pend keeps a store waiting behind a read.
    task automatic txn(input int kind, input logic [1:0] size, input logic [31:0] op1,
                       input logic [31:0] op2, input logic [31:0] pc, input logic [31:0] rd,
                       input int delay, input bit drop, input bit pend, input int pf_wait,
                       input bit e_err, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                       input logic [3:0] e_wstrb, input logic [31:0] e_rw);
        bit pf, pf2;
        mem_wordsize = size; reg_op1 = op1; reg_op2 = op2; next_pc = pc;
        case (kind)
            0:       mem_do_rinst = 1;
            1:       mem_do_prefetch = 1;
            2:       mem_do_rdata = 1;
            default: mem_do_wdata = 1;
        endcase
        if (pend) mem_do_wdata = 1;
        idle_model();
        @(posedge clk); #1;
        if (e_err) begin
            all_low();
            m_err = 1;
            @(posedge clk); #1;
            m_err = 0;
            return;
        end
        bus_phase(kind != 3, kind < 2, e_addr, e_wdata, e_wstrb, rd, e_rw, delay, drop, pf);
        if (pend) begin
            mem_do_rinst = 0; mem_do_rdata = 0;
            @(posedge clk); #1;
            bus_phase(0, 0, op1 & 32'hFFFF_FFFC, wdata_of(size, op2), strb_of(size, op1[1:0]),
                      $urandom, 32'h0, $urandom_range(0, 2), 0, pf2);
        end
        all_low();
        if (pf) begin
            repeat (pf_wait) begin @(posedge clk); #1; end
            mem_do_rinst = 1;
            m_done = 1;
            @(posedge clk); #1;
            mem_do_rinst = 0;
            m_done = 0;
        end
    endtask

    task automatic rand_txn();
        int kind, delay, pf_wait;
        logic [1:0] size, off;
        logic [31:0] op1, op2, pc, rd;
        bit drop, pend, e_err;
        kind  = $urandom_range(0, 3);
        size  = 2'($urandom_range(0, 3));
        op1   = $urandom; op2 = $urandom; pc = $urandom; rd = $urandom;
        delay = $urandom_range(0, 3);
        pf_wait = $urandom_range(0, 3);
        pend  = (kind == 0 || kind == 2) && ($urandom_range(0, 3) == 0);
        drop  = !pend && delay > 0 && ($urandom_range(0, 5) == 0);
        if (pend || $urandom_range(0, 9) < 7) begin
            size = 2'($urandom_range(0, 2));
            if (size == 2'd0) op1[1:0] = 2'b00;
            if (size == 2'd1) op1[0] = 1'b0;
        end
        off   = op1[1:0];
        e_err = (kind >= 2) && bad_of(size, off);
        txn(kind, size, op1, op2, pc, rd, delay, drop, pend, pf_wait, e_err,
            (kind < 2) ? (pc & 32'hFFFF_FFFC) : (op1 & 32'hFFFF_FFFC),
            wdata_of(size, op2),
            (kind == 3) ? strb_of(size, off) : 4'h0,
            (kind < 2) ? rd : rw_of(size, off, rd));
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit pf;
        resetn = 0; all_low();
        mem_wordsize = 0; next_pc = 0; reg_op1 = 0; reg_op2 = 0;
        mem_ready = 0; mem_rdata = 0;
        m_chk_all = 1;
        repeat (2) @(posedge clk);
        #3 resetn = 1;
        @(posedge clk); #1;
        m_chk_all = 0;

        // Literal scenarios
        txn(0, 2'd0, 32'h0, 32'h0, 32'h0000_0106, 32'h1234_5678, 1, 0, 0, 0,
            0, 32'h0000_0104, 32'h0, 4'h0, 32'h1234_5678);
        txn(3, 2'd2, 32'h0000_0203, 32'h0000_00A5, 32'h0, 32'h0, 0, 0, 0, 0,
            0, 32'h0000_0200, 32'hA5A5_A5A5, 4'b1000, 32'h0);
        txn(2, 2'd1, 32'h0000_0302, 32'h0, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0,
            0, 32'h0000_0300, 32'h0, 4'h0, 32'h0000_BEEF);
        txn(1, 2'd0, 32'h0, 32'h0, 32'h0000_0800, 32'hCAFE_F00D, 0, 0, 0, 3,
            0, 32'h0000_0800, 32'h0, 4'h0, 32'hCAFE_F00D);
        txn(2, 2'd0, 32'h0000_0401, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            1, 32'h0, 32'h0, 4'h0, 32'h0);
        txn(2, 2'd3, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0,
            1, 32'h0, 32'h0, 4'h0, 32'h0);
        txn(0, 2'd1, 32'h0000_0906, 32'h0000_7788, 32'h0000_0A03, 32'h1111_2222, 2, 0, 1, 0,
            0, 32'h0000_0A00, 32'h0, 4'h0, 32'h1111_2222);
        txn(2, 2'd2, 32'h0000_0C01, 32'h0, 32'h0, 32'h8899_AABB, 2, 1, 0, 1,
            0, 32'h0000_0C00, 32'h0, 4'h0, 32'h0000_00AA);

        // Reset in the middle of a transfer
        mem_do_rinst = 1; next_pc = 32'h0000_0500;
        @(posedge clk); #1;
        m_valid = 1; m_addr = 32'h0000_0500; m_instr = 1; m_wstrb = 0; m_is_read = 1;
        @(posedge clk); #1;
        resetn = 0;
        idle_model();
        m_chk_all = 1; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_instr = 0;
        next_pc = 32'h0000_0600;
        @(posedge clk); #3;
        resetn = 1;
        @(posedge clk); #1;
        m_chk_all = 0;
        bus_phase(1, 1, 32'h0000_0600, 32'h0, 4'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0, pf);
        all_low();
        @(posedge clk); #1;

        for (int i = 0; i < 400; i++) rand_txn();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
